// File: rtl/isp_route_pkg.sv
// Shared constants, types and the route table for the ISP route switch.
package isp_route_pkg;

    localparam int SLOT_DPC       = 0;
    localparam int SLOT_DEBAYER_L = 1;
    localparam int SLOT_DEBAYER_M = 2;
    localparam int SLOT_DEBAYER_H = 3;
    localparam int SLOT_AWB       = 4;
    localparam int SLOT_YUV       = 5;
    localparam int SLOT_RAW2RGB   = 6;
    // Pseudo-slot used to ask the route table where the HDMI output comes from.
    localparam int SLOT_OUT       = 7;

    localparam logic [3:0] SRC_CAM  = 4'd7;
    localparam logic [3:0] SRC_NONE = 4'd15;

    typedef enum logic [3:0] {
        MODE_BYPASS  = 4'd0,
        MODE_DBL     = 4'd1,
        MODE_DBM     = 4'd2,
        MODE_DBH     = 4'd3,
        MODE_DBL_AWB = 4'd4,
        MODE_DBL_YUV = 4'd5,
        MODE_DBH_YUV = 4'd6,
        MODE_DBM_AWB = 4'd7
    } mode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Source code for a slot input (or SLOT_OUT): SRC_CAM, a stage slot index, or SRC_NONE.
    function automatic logic [3:0] route_src(input logic [3:0] mode, input int slot);
        logic [3:0] r;
        r = SRC_NONE;
        case (mode)
            MODE_BYPASS: begin
                if (slot == SLOT_RAW2RGB) r = SRC_CAM;
                if (slot == SLOT_OUT)     r = 4'(SLOT_RAW2RGB);
            end
            MODE_DBL: begin
                if (slot == SLOT_DPC)       r = SRC_CAM;
                if (slot == SLOT_DEBAYER_L) r = 4'(SLOT_DPC);
                if (slot == SLOT_OUT)       r = 4'(SLOT_DEBAYER_L);
            end
            MODE_DBM: begin
                if (slot == SLOT_DPC)       r = SRC_CAM;
                if (slot == SLOT_DEBAYER_M) r = 4'(SLOT_DPC);
                if (slot == SLOT_OUT)       r = 4'(SLOT_DEBAYER_M);
            end
            MODE_DBH: begin
                if (slot == SLOT_DPC)       r = SRC_CAM;
                if (slot == SLOT_DEBAYER_H) r = 4'(SLOT_DPC);
                if (slot == SLOT_OUT)       r = 4'(SLOT_DEBAYER_H);
            end
            MODE_DBL_AWB: begin
                if (slot == SLOT_DPC)       r = SRC_CAM;
                if (slot == SLOT_DEBAYER_L) r = 4'(SLOT_DPC);
                if (slot == SLOT_AWB)       r = 4'(SLOT_DEBAYER_L);
                if (slot == SLOT_OUT)       r = 4'(SLOT_AWB);
            end
            MODE_DBL_YUV: begin
                if (slot == SLOT_DPC)       r = SRC_CAM;
                if (slot == SLOT_DEBAYER_L) r = 4'(SLOT_DPC);
                if (slot == SLOT_AWB)       r = 4'(SLOT_DEBAYER_L);
                if (slot == SLOT_YUV)       r = 4'(SLOT_AWB);
                if (slot == SLOT_OUT)       r = 4'(SLOT_YUV);
            end
            MODE_DBH_YUV: begin
                if (slot == SLOT_DPC)       r = SRC_CAM;
                if (slot == SLOT_DEBAYER_H) r = 4'(SLOT_DPC);
                if (slot == SLOT_AWB)       r = 4'(SLOT_DEBAYER_H);
                if (slot == SLOT_YUV)       r = 4'(SLOT_AWB);
                if (slot == SLOT_OUT)       r = 4'(SLOT_YUV);
            end
            MODE_DBM_AWB: begin
                if (slot == SLOT_DPC)       r = SRC_CAM;
                if (slot == SLOT_DEBAYER_M) r = 4'(SLOT_DPC);
                if (slot == SLOT_AWB)       r = 4'(SLOT_DEBAYER_M);
                if (slot == SLOT_OUT)       r = 4'(SLOT_AWB);
            end
            default: r = SRC_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/isp_route_fsm.sv
// Mode-switch controller: vsync edge detect, RUN/PEND/FLUSH FSM, flush counter,
// applied mode and sticky illegal-request flag.
module isp_route_fsm
    import isp_route_pkg::*;
#(
    parameter int MODE_W       = 4,
    parameter int N_MODE       = 8,
    parameter int FLUSH_FRAMES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_req,
    input  logic              src_vs,
    output logic [MODE_W-1:0] mode_active,
    output logic              switch_busy,
    output logic              flush,
    output logic              mode_err
);

    state_e            r_state, w_state_nxt;
    logic [MODE_W-1:0] r_mode, w_mode_nxt;
    logic [MODE_W-1:0] r_pend, w_pend_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_err, w_err_nxt;
    logic              r_vs_d;
    logic              w_vs_rise, w_legal, w_diff;

    assign w_vs_rise = src_vs & ~r_vs_d;
    assign w_legal   = {1'b0, mode_req} < (MODE_W+1)'(N_MODE);
    assign w_diff    = mode_req != r_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_mode  <= '0;
            r_pend  <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_vs_d  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_pend  <= w_pend_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_vs_d  <= src_vs;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_pend_nxt  = r_pend;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        if (!w_legal) w_err_nxt = 1'b1;
        case (r_state)
            ST_RUN: begin
                if (w_legal && w_diff) begin
                    w_err_nxt = 1'b0;
                    if (w_vs_rise) begin
                        w_mode_nxt  = mode_req;
                        w_cnt_nxt   = 4'(FLUSH_FRAMES);
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_pend_nxt  = mode_req;
                        w_state_nxt = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!w_diff) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    if (w_legal) w_pend_nxt = mode_req;
                    // An illegal level at the edge falls back to the last legal request.
                    if (w_vs_rise) begin
                        w_mode_nxt  = w_legal ? mode_req : r_pend;
                        w_cnt_nxt   = 4'(FLUSH_FRAMES);
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_vs_rise) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign mode_active = r_mode;
    assign switch_busy = r_state != ST_RUN;
    assign flush       = r_state == ST_FLUSH;
    assign mode_err    = r_err;

endmodule

// File: rtl/isp_route_switch.sv
// Frame-synchronous ISP route crossbar. Build with ISP_ROUTE_PATTERN_EN to emit
// mid-grey with live data enable during the post-switch flush instead of blanking.
module isp_route_switch
    import isp_route_pkg::*;
#(
    parameter int DW           = 24,
    parameter int N_STAGE      = 7,
    parameter int MODE_W       = 4,
    parameter int N_MODE       = 8,
    parameter int FLUSH_FRAMES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MODE_W-1:0]     mode_req,
    input  logic [DW-1:0]         src_data,
    input  logic                  src_de,
    input  logic                  src_vs,
    input  logic [N_STAGE*DW-1:0] stg_out,
    output logic [N_STAGE*DW-1:0] stg_in,
    output logic [DW-1:0]         hdmi_data,
    output logic                  hdmi_de,
    output logic [MODE_W-1:0]     mode_active,
    output logic                  switch_busy,
    output logic                  mode_err
);

`ifdef ISP_ROUTE_PATTERN_EN
    localparam logic [DW-1:0] BLANK    = DW'(24'h808080);
    localparam logic          FLUSH_DE = 1'b1;
`else
    localparam logic [DW-1:0] BLANK    = '0;
    localparam logic          FLUSH_DE = 1'b0;
`endif

    logic          w_flush;
    logic [3:0]    w_mode4;
    logic [DW-1:0] w_stg_out [N_STAGE];
    logic [DW-1:0] w_out;
    logic [3:0]    w_out_code;
    logic [DW-1:0] r_hdmi_data;
    logic          r_hdmi_de;

    isp_route_fsm #(
        .MODE_W       (MODE_W),
        .N_MODE       (N_MODE),
        .FLUSH_FRAMES (FLUSH_FRAMES)
    ) u_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode_req    (mode_req),
        .src_vs      (src_vs),
        .mode_active (mode_active),
        .switch_busy (switch_busy),
        .flush       (w_flush),
        .mode_err    (mode_err)
    );

    assign w_mode4 = 4'(mode_active);

    for (genvar g = 0; g < N_STAGE; g++) begin : g_slot
        logic [3:0]    w_code;
        logic [DW-1:0] w_in;
        assign w_stg_out[g] = stg_out[g*DW +: DW];
        assign w_code       = route_src(w_mode4, g);
        always_comb begin
            w_in = '0;
            if (w_code == SRC_CAM) w_in = src_data;
            for (int k = 0; k < N_STAGE; k++)
                if (w_code == 4'(k)) w_in = w_stg_out[k];
        end
        assign stg_in[g*DW +: DW] = w_in;
    end

    assign w_out_code = route_src(w_mode4, SLOT_OUT);
    always_comb begin
        w_out = '0;
        for (int k = 0; k < N_STAGE; k++)
            if (w_out_code == 4'(k)) w_out = w_stg_out[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdmi_data <= '0;
            r_hdmi_de   <= 1'b0;
        end else if (w_flush) begin
            r_hdmi_data <= BLANK;
            r_hdmi_de   <= FLUSH_DE & src_de;
        end else begin
            r_hdmi_data <= w_out;
            r_hdmi_de   <= src_de;
        end
    end

    assign hdmi_data = r_hdmi_data;
    assign hdmi_de   = r_hdmi_de;

endmodule

// File: doc/isp_route_switch.md
Name: isp_route_switch

Overview:
- Parametrised, registered successor to the ISP mode crossbar.
- Routes the camera pixel stream through a mode-selected chain of ISP stages and on to the HDMI path.
- Mode changes are applied only at frame boundaries, followed by a pipeline-flush blanking window.
- Sits between the SDRAM read-out / bayer source and the HDMI timing/encoder.

Parameters:
- DW, 24: pixel data width.
- N_STAGE, 7: number of ISP stage slots. Slot order: 0 dpc, 1 debayer_l, 2 debayer_m, 3 debayer_h, 4 awb, 5 yuv, 6 raw2rgb.
- MODE_W, 4: width of mode_req.
- N_MODE, 8: number of legal modes, 0..N_MODE-1.
- FLUSH_FRAMES, 1: frames blanked after a switch, 1..15.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- mode_req  in  MODE_W  requested route mode; level, may change any cycle.
- src_data  in  DW  source pixel.
- src_de  in  1  data enable.
- src_vs  in  1  vsync, active high.
- stg_out  in  N_STAGE*DW  flattened stage outputs; slot i at [i*DW +: DW].
- stg_in  out  N_STAGE*DW  flattened stage inputs.
- hdmi_data  out  DW  pixel to HDMI.
- hdmi_de  out  1  enable to HDMI.
- mode_active  out  MODE_W  mode currently applied.
- switch_busy  out  1  high from request detection until the flush ends.
- mode_err  out  1  sticky illegal-request flag.

Behaviour:
- Reset values: mode_active = 0, hdmi_data = 0, hdmi_de = 0, switch_busy = 0, mode_err = 0. FSM in RUN. Flush counter = 0.
- Route table (source codes: S = src_data, k = stg_out slot k):
  - mode0: raw2rgb←S; out←6.
  - mode1: dpc←S; debayer_l←0; out←1.
  - mode2: dpc←S; debayer_m←0; out←2.
  - mode3: dpc←S; debayer_h←0; out←3.
  - mode4: dpc←S; debayer_l←0; awb←1; out←4.
  - mode5: mode4 chain, plus yuv←4; out←5.
  - mode6: dpc←S; debayer_h←0; awb←3; yuv←4; out←5.
  - mode7: dpc←S; debayer_m←0; awb←2; out←4.
- Every stage slot not used by mode_active drives stg_in = 0. No latched or stale values.
- stg_in is combinational from mode_active, the src/stg buses and a registered mode. It has no latency.
- hdmi_data / hdmi_de are registered: 1-cycle latency from the selected source and src_de.
- FSM:
  - RUN: a mode_req that differs from mode_active and is < N_MODE → PEND, switch_busy = 1.
  - PEND: on the src_vs rising edge (detected with a 1-cycle-delayed copy), load mode_active ← the latest mode_req and load flush counter ← FLUSH_FRAMES; → FLUSH.
  - FLUSH: hdmi_de forced 0 and hdmi_data forced to the blank value. Each src_vs rising edge decrements the counter. The edge where the counter hits 0 → RUN, switch_busy = 0.
- mode_req ≥ N_MODE: ignored. mode_err set, and cleared the next time a legal request differing from mode_active is accepted. mode_active unchanged.
- If mode_req returns to mode_active while in PEND: → RUN with no switch and no flush.
- A new legal request during FLUSH is held. It is re-evaluated in RUN on the next cycle and starts a fresh PEND.
- src_vs rising edge in the same cycle a request is first detected: the switch is taken at that edge.
- Reset mid-operation: all state returns to reset values immediately. Routing falls back to mode0.

Optional Feature:
- ISP_ROUTE_PATTERN_EN
  - Defined: during FLUSH, hdmi_de follows src_de (registered) and hdmi_data = 24'h808080 mid-grey, so the monitor keeps sync and shows grey.
  - Undefined: during FLUSH, hdmi_de = 0 and hdmi_data = 0.

Decomposition:
- Package isp_route_pkg holds:
  - slot index constants (SLOT_DPC .. SLOT_RAW2RGB) and the SRC_CAM code;
  - the mode enum (MODE_BYPASS .. MODE_DBM_AWB);
  - the FSM state typedef;
  - a constant route-table function route_src(mode, slot), returning a source code or NONE.
- One sub-module: isp_route_fsm, holding the vsync edge detection, FSM, flush counter, mode_active and mode_err. The mux datapath stays in the top.

Test Plan:
- Reset, mode_req = 0, ramp on src_data, stg_out slot 6 = src+1 → hdmi_data = src+1 one cycle later; all stg_in except slot 6 = 0.
- mode_req 0→5 mid-frame → mode_active stays 0 until the next src_vs rise, then becomes 5. With FLUSH_FRAMES = 1, hdmi_de = 0 for exactly one frame, then out = slot 5. awb_in = slot 1 and yuv_in = slot 4.
- mode_req = 9 → mode_err = 1, mode_active unchanged, no flush. A later mode_req = 3 clears mode_err after acceptance.
- mode_req 2→4→2 (mode_active = 2) before any vsync → back in RUN, no flush, switch_busy pulses only for those cycles.
- rst_n low during FLUSH → all outputs 0, mode_active = 0 in the same cycle. With ISP_ROUTE_PATTERN_EN, re-run the switch case: hdmi_data = 808080 with de following src_de during flush.
